// File: rtl/trigger_capture_if.sv
// Bus bundle for trigger_capture: trigger/control inputs, captured sample and status outputs.
interface trigger_capture_if #(
    parameter int unsigned R = 14,
    parameter int unsigned D = 24,
    parameter int unsigned C = 16
);
    logic                trig_tick;
    logic                enable;
    logic                mode_cont;
    logic                clr_cnt;
    logic [D-1:0]        delay;
    logic [D-1:0]        holdoff;
    logic signed [R-1:0] data_in;
    logic signed [R-1:0] data_out;
    logic                valid;
    logic                busy;
    logic                armed;
    logic [C-1:0]        trig_cnt;
    logic [C-1:0]        miss_cnt;

    modport master (
        output trig_tick, enable, mode_cont, clr_cnt, delay, holdoff, data_in,
        input  data_out, valid, busy, armed, trig_cnt, miss_cnt
    );

    modport slave (
        input  trig_tick, enable, mode_cont, clr_cnt, delay, holdoff, data_in,
        output data_out, valid, busy, armed, trig_cnt, miss_cnt
    );
endinterface

// File: rtl/trigger_capture.sv
// Delayed sample capture on trigger tick rising edge, with hold-off re-arm and
// saturating accepted/missed trigger counters.
module trigger_capture #(
    parameter int unsigned R = 14,
    parameter int unsigned D = 24,
    parameter int unsigned C = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    trigger_capture_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] DELAY = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [C-1:0] CNT_MAX = '1;

    logic [2:0]          state, state_nxt;
    logic [D-1:0]        cnt, cnt_nxt;
    logic                tick_d;
    logic                tick_rise_c;
    logic signed [R-1:0] data_q, data_nxt;
    logic                valid_q, valid_nxt;
    logic [C-1:0]        trig_q, trig_nxt;
    logic [C-1:0]        miss_q, miss_nxt;
    logic                trig_inc, miss_inc;
    logic                busy_q, armed_q;

    assign tick_rise_c = bus.trig_tick & ~tick_d;

    // State register plus every datapath/status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tick_d  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            trig_q  <= '0;
            miss_q  <= '0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tick_d  <= bus.trig_tick;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            trig_q  <= trig_nxt;
            miss_q  <= miss_nxt;
            busy_q  <= (state_nxt == DELAY) || (state_nxt == HOLD);
            armed_q <= (state_nxt == ARMED);
        end
    end

    // Next state, counter load/decrement, capture and trigger accounting
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        trig_inc  = 1'b0;
        miss_inc  = 1'b0;

        if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = ARMED;
                ARMED: begin
                    if (tick_rise_c) begin
                        state_nxt = DELAY;
                        cnt_nxt   = bus.delay;
                        trig_inc  = 1'b1;
                    end
                end
                DELAY: begin
                    miss_inc = tick_rise_c;
                    if (cnt == '0) begin
                        data_nxt  = bus.data_in;
                        valid_nxt = 1'b1;
                        cnt_nxt   = bus.holdoff;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt - D'(1);
                    end
                end
                HOLD: begin
                    miss_inc = tick_rise_c;
                    if (cnt == '0) begin
                        state_nxt = bus.mode_cont ? ARMED : DONE;
                    end else begin
                        cnt_nxt = cnt - D'(1);
                    end
                end
                DONE:    miss_inc  = tick_rise_c;
                default: state_nxt = IDLE;
            endcase
        end

        trig_nxt = (trig_inc && (trig_q != CNT_MAX)) ? trig_q + C'(1) : trig_q;
        miss_nxt = (miss_inc && (miss_q != CNT_MAX)) ? miss_q + C'(1) : miss_q;
        // Clear beats a coincident increment
        if (bus.clr_cnt) begin
            trig_nxt = '0;
            miss_nxt = '0;
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.armed    = armed_q;
    assign bus.trig_cnt = trig_q;
    assign bus.miss_cnt = miss_q;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: a 16-bit-counter instance for function,
// and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_trigger_capture;
    logic               clk;
    logic               rst_n;
    logic               trig_tick;
    logic               enable;
    logic               mode_cont;
    logic               clr_cnt;
    logic [23:0]        delay;
    logic [23:0]        holdoff;
    logic signed [13:0] data_in;

    int checks = 0;
    int errors = 0;

    trigger_capture_if #(.R(14), .D(24), .C(16)) bus  ();
    trigger_capture_if #(.R(14), .D(24), .C(4))  bus4 ();

    assign bus.trig_tick  = trig_tick;
    assign bus.enable     = enable;
    assign bus.mode_cont  = mode_cont;
    assign bus.clr_cnt    = clr_cnt;
    assign bus.delay      = delay;
    assign bus.holdoff    = holdoff;
    assign bus.data_in    = data_in;
    assign bus4.trig_tick = trig_tick;
    assign bus4.enable    = enable;
    assign bus4.mode_cont = mode_cont;
    assign bus4.clr_cnt   = clr_cnt;
    assign bus4.delay     = delay;
    assign bus4.holdoff   = holdoff;
    assign bus4.data_in   = data_in;

    trigger_capture #(.R(14), .D(24), .C(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    trigger_capture #(.R(14), .D(24), .C(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic tick;
        int   din;
        logic e_valid;
        logic e_busy;
        logic e_armed;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick in cycle 0 (one cycle wide); returns the cycle in which valid is seen, or -1
    task automatic fire(input int bound, input int chg_at, input logic [23:0] chg_val,
                        output int lat);
        lat = -1;
        trig_tick = 1'b1;
        for (int k = 0; k < bound; k++) begin
            if (k == 1) trig_tick = 1'b0;
            if (k == chg_at) delay = chg_val;
            if (bus.valid) begin
                lat = k;
                break;
            end
            step();
        end
        trig_tick = 1'b0;
    endtask

    vec_t t1 [12];
    int   lat;
    int   nval;
    logic seen_valid;

    initial begin
        for (int k = 0; k < 12; k++) begin
            t1[k].tick    = (k < 8);
            t1[k].din     = 100 + k;
            t1[k].e_valid = (k == 7);
            t1[k].e_busy  = (k >= 1) && (k <= 7);
            t1[k].e_armed = (k == 0);
        end

        rst_n = 1'b0; trig_tick = 1'b0; enable = 1'b0; mode_cont = 1'b0; clr_cnt = 1'b0;
        delay = 24'd5; holdoff = 24'd0; data_in = 14'sd0;
        #12;
        chk("rst_data_out", longint'(bus.data_out), 0);
        chk("rst_valid", longint'(bus.valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_armed", longint'(bus.armed), 0);
        chk("rst_trig_cnt", longint'(bus.trig_cnt), 0);
        chk("rst_miss_cnt", longint'(bus.miss_cnt), 0);
        rst_n = 1'b1;
        enable = 1'b1;
        step();

        // Single shot, delay 5, 8-cycle tick, ramping data
        for (int k = 0; k < 12; k++) begin
            trig_tick = t1[k].tick;
            data_in   = 14'(t1[k].din);
            chk($sformatf("t1_valid_c%0d", k), longint'(bus.valid), longint'(t1[k].e_valid));
            chk($sformatf("t1_busy_c%0d", k),  longint'(bus.busy),  longint'(t1[k].e_busy));
            chk($sformatf("t1_armed_c%0d", k), longint'(bus.armed), longint'(t1[k].e_armed));
            step();
        end
        chk("t1_data_out", longint'(bus.data_out), 106);
        chk("t1_trig_cnt", longint'(bus.trig_cnt), 1);
        chk("t1_miss_cnt", longint'(bus.miss_cnt), 0);

        // Continuous, delay 0, holdoff 3, tick rise every 2 cycles
        enable = 1'b0; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; mode_cont = 1'b1; delay = 24'd0; holdoff = 24'd3; enable = 1'b1;
        step();
        chk("t2_armed", longint'(bus.armed), 1);
        chk("t2_trig_clr", longint'(bus.trig_cnt), 0);
        nval = 0;
        for (int k = 0; k < 22; k++) begin
            trig_tick = (k < 20) && (k % 2 == 0);
            data_in   = 14'(1000 + k);
            chk($sformatf("t2_valid_c%0d", k), longint'(bus.valid),
                longint'((k == 2) || (k == 8) || (k == 14) || (k == 20)));
            if (bus.valid) nval++;
            step();
        end
        chk("t2_valid_count", nval, 4);
        chk("t2_data_out", longint'(bus.data_out), 1019);
        chk("t2_trig_cnt", longint'(bus.trig_cnt), 4);
        chk("t2_miss_cnt", longint'(bus.miss_cnt), 6);

        // Abort during a long delay
        enable = 1'b0;
        step();
        mode_cont = 1'b0; delay = 24'd100; holdoff = 24'd0; data_in = 14'sd555; enable = 1'b1;
        step();
        seen_valid = 1'b0;
        trig_tick = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            if (k == 1) trig_tick = 1'b0;
            if (bus.valid) seen_valid = 1'b1;
            if (k == 50) begin
                chk("t3_busy_c50", longint'(bus.busy), 1);
                enable = 1'b0;
            end
            step();
        end
        chk("t3_busy_c51", longint'(bus.busy), 0);
        chk("t3_armed_c51", longint'(bus.armed), 0);
        chk("t3_valid_c51", longint'(bus.valid), 0);
        chk("t3_no_valid", longint'(seen_valid), 0);
        chk("t3_data_kept", longint'(bus.data_out), 1019);
        chk("t3_trig_cnt", longint'(bus.trig_cnt), 5);
        trig_tick = 1'b1;
        step();
        trig_tick = 1'b0;
        step();
        chk("t3_idle_tick_miss", longint'(bus.miss_cnt), 6);
        chk("t3_idle_tick_trig", longint'(bus.trig_cnt), 5);
        delay = 24'd3; data_in = -14'sd777; enable = 1'b1;
        step();
        chk("t3_rearmed", longint'(bus.armed), 1);
        fire(20, -1, 24'd0, lat);
        chk("t3_latency", lat, 5);
        chk("t3_data_out", longint'(bus.data_out), -777);
        chk("t3_trig_cnt2", longint'(bus.trig_cnt), 6);

        // Delay changed mid-count; next capture uses new value
        enable = 1'b0;
        step();
        mode_cont = 1'b1; holdoff = 24'd0; delay = 24'd10; enable = 1'b1;
        step();
        fire(30, 3, 24'd2, lat);
        chk("t6_latency_old", lat, 12);
        step();
        chk("t6_rearmed", longint'(bus.armed), 1);
        fire(30, -1, 24'd0, lat);
        chk("t6_latency_new", lat, 4);

        // Saturation on the 4-bit instance, then clear against an accepted tick
        enable = 1'b0; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; mode_cont = 1'b1; delay = 24'd0; holdoff = 24'd0; enable = 1'b1;
        step();
        for (int n = 0; n < 20; n++) begin
            trig_tick = 1'b1;
            step();
            trig_tick = 1'b0;
            step(); step(); step();
        end
        chk("t4_sat_trig4", longint'(bus4.trig_cnt), 15);
        chk("t4_trig16", longint'(bus.trig_cnt), 20);
        chk("t4_miss4", longint'(bus4.miss_cnt), 0);
        chk("t4_armed", longint'(bus.armed), 1);
        trig_tick = 1'b1; clr_cnt = 1'b1;
        step();
        trig_tick = 1'b0; clr_cnt = 1'b0;
        chk("t4_clr_trig4", longint'(bus4.trig_cnt), 0);
        chk("t4_clr_trig16", longint'(bus.trig_cnt), 0);
        chk("t4_clr_busy", longint'(bus.busy), 1);

        // Async reset between edges in the middle of DELAY
        step(); step();
        chk("t5_armed", longint'(bus.armed), 1);
        delay = 24'd20;
        trig_tick = 1'b1;
        step();
        trig_tick = 1'b0;
        step(); step(); step(); step();
        chk("t5_pre_busy", longint'(bus.busy), 1);
        chk("t5_pre_trig", longint'(bus.trig_cnt), 1);
        chk("t5_pre_data", longint'(bus.data_out), -777);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data_out", longint'(bus.data_out), 0);
        chk("t5_rst_busy", longint'(bus.busy), 0);
        chk("t5_rst_armed", longint'(bus.armed), 0);
        chk("t5_rst_valid", longint'(bus.valid), 0);
        chk("t5_rst_trig", longint'(bus.trig_cnt), 0);
        chk("t5_rst_miss", longint'(bus.miss_cnt), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        chk("t5_post_armed", longint'(bus.armed), 1);
        chk("t5_post_busy", longint'(bus.busy), 0);
        delay = 24'd4; data_in = 14'sd321;
        fire(20, -1, 24'd0, lat);
        chk("t5_latency", lat, 6);
        chk("t5_data_out", longint'(bus.data_out), 321);
        chk("t5_trig_cnt", longint'(bus.trig_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Downstream consumer of the trigger tick generator (`trig_tick`, a high pulse lasting 2**N clocks).
- On each accepted tick, waits a programmable delay, then samples a signed data word (error or PID signal) into a held output register.
- After capture, applies a hold-off before re-arming.
- Supports single-shot and continuous modes. Reports an accepted-trigger count and a missed-trigger count for the register map.

Parameters:
- R, 14, data word width (signed)
- D, 24, delay and hold-off counter width
- C, 16, trigger counter width

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- trig_tick, in, 1, tick from trigger generator; may stay high for several cycles
- enable, in, 1, level; 1 = run, 0 = abort and idle
- mode_cont, in, 1, 1 = continuous re-arm, 0 = single shot
- clr_cnt, in, 1, synchronous clear of both counters
- delay, in, D, cycles from tick to sample
- holdoff, in, D, dead time after a capture
- data_in, in, R, signed sample source
- data_out, out, R, held captured sample
- valid, out, 1, one-cycle pulse when data_out updates
- busy, out, 1, high in DELAY or HOLD
- armed, out, 1, high in ARMED
- trig_cnt, out, C, accepted triggers, saturating
- miss_cnt, out, C, ticks ignored while busy or done, saturating

Behaviour:
- Reset: asynchronous on rst_n low. All registers go to 0, state = IDLE, data_out = 0, valid = 0, counters = 0. Leaving reset is synchronous to clk.
- Edge detection:
  - tick_d is trig_tick registered one cycle.
  - tick_rise = trig_tick & ~tick_d, evaluated combinationally.
  - Only tick_rise counts as an event, so a multi-cycle tick produces exactly one event.
- States: IDLE, ARMED, DELAY, HOLD, DONE.
- Abort: enable = 0 in any state forces IDLE on the next edge. data_out is retained, no valid pulse, counters are kept. Abort has priority over every other transition.
- IDLE → ARMED when enable = 1.
- ARMED:
  - On tick_rise → DELAY, cnt <= delay, trig_cnt += 1.
  - Otherwise stay in ARMED.
- DELAY:
  - If cnt == 0: data_out <= data_in, valid <= 1 for one cycle, cnt <= holdoff, → HOLD.
  - Otherwise cnt -= 1.
- HOLD:
  - If cnt == 0: → ARMED when mode_cont = 1, else → DONE.
  - Otherwise cnt -= 1.
- DONE: stays until enable = 0, which gives IDLE. The next enable = 1 then re-arms.
- Timing: if tick_rise is first high in cycle 0, data_in is sampled from cycle 1+delay, and valid is high in cycle 2+delay.
- Hold-off: HOLD occupies holdoff+1 cycles. The earliest next accepted tick_rise is in cycle 3+delay+holdoff.
- Missed triggers: a tick_rise in DELAY, HOLD or DONE increments miss_cnt. In IDLE it is ignored and not counted.
- Parameter sampling: delay and holdoff are read only when loaded. Changing them mid-count has no effect on the current count.
- Counter saturation and clear:
  - trig_cnt and miss_cnt stop at all-ones and do not wrap.
  - clr_cnt zeroes both counters. If clr_cnt coincides with an increment, the clear wins: result 0.
- Outputs:
  - busy = (state == DELAY) | (state == HOLD).
  - armed = (state == ARMED).
  - Both are decoded from registered state; there is no input-to-output combinational path.
- Data handling: data_out is a plain register copy of data_in (signed), with no arithmetic and no width change.

Test Plan:
1. Single shot, delay = 5, holdoff = 0, mode_cont = 0, data_in ramps +1 per cycle from 100, tick high 8 cycles starting at cycle 0 → data_out = 106, valid high only in cycle 7, trig_cnt = 1, miss_cnt = 0 (tick still high is not re-counted), state ends in DONE.
2. Continuous, delay = 0, holdoff = 3, tick_rise every 2 cycles for 20 cycles → capture every 6 cycles (4 captures), trig_cnt = 4, miss_cnt = 6, valid pulses one cycle each.
3. Abort: tick accepted with delay = 100, enable dropped at cycle 50 → IDLE at cycle 51, no valid pulse, data_out unchanged. Re-enable followed by a tick → normal capture.
4. Saturation with C = 4: 20 accepted triggers → trig_cnt holds at 15. clr_cnt pulsed in the same cycle as a tick_rise → trig_cnt = 0.
5. Asynchronous reset asserted mid-DELAY, between clock edges → all outputs 0 immediately without a clock edge, state IDLE after release, first capture after re-arm is correct.
6. delay changed from 10 to 2 during DELAY → the current capture still occurs at cycle 11; the next capture uses 2.
